// File: rtl/pwm_audio_pkg.sv
// Shared constants and helpers for the PWM audio path.
// The effective PWM period is the next power of two at or above the requested length.
package pwm_audio_pkg;

  localparam int DEFAULT_PULSE_PERIOD = 16;
  localparam int DEFAULT_INPUT_BITS   = 4;
  localparam int DEFAULT_FIFO_DEPTH   = 8;

  // Where the next sample value comes from on a given edge
  typedef enum logic [1:0] {
    SRC_KEEP = 2'd0,
    SRC_ZERO = 2'd1,
    SRC_HEAD = 2'd2
  } sample_src_e;

  function automatic int period_len(input int x);
    return 1 << $clog2(x);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with registered full, empty and level flags.
// Pushes into a full FIFO and pops from an empty one are ignored.
module sample_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    full_d  = (level_d == DEPTH_L);
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: the pointers and level fully define what is valid
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign level = level_q;

endmodule

// File: rtl/sample_feeder.sv
// Buffers upstream samples and hands one to the PWM converter per PWM period.
// Define SAMPLE_HOLD_ON_UNDERRUN_EN to repeat the last sample on underrun instead of outputting 0.
module sample_feeder
  import pwm_audio_pkg::*;
#(
  parameter int PULSE_PERIOD = DEFAULT_PULSE_PERIOD,
  parameter int INPUT_BITS   = DEFAULT_INPUT_BITS,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [INPUT_BITS-1:0]        in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   vol_shift,
  input  logic                         clear_underrun,
  output logic [INPUT_BITS-1:0]        sample,
  output logic                         period_start,
  output logic                         underrun,
  output logic [$clog2(FIFO_DEPTH):0]  level
);

  localparam int P  = period_len(PULSE_PERIOD);
  localparam int CW = $clog2(P);
  localparam logic [CW-1:0] PCNT_LAST = CW'(P - 1);

`ifdef SAMPLE_HOLD_ON_UNDERRUN_EN
  localparam sample_src_e UNDERRUN_SRC = SRC_KEEP;
`else
  localparam sample_src_e UNDERRUN_SRC = SRC_ZERO;
`endif

  logic [CW-1:0]         pcnt_q, pcnt_d;
  logic [INPUT_BITS-1:0] sample_q, sample_d;
  logic                  period_start_q, period_start_d;
  logic                  underrun_q, underrun_d;

  logic                  boundary;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [INPUT_BITS-1:0] fifo_head;
  sample_src_e           src;

  assign boundary = en && (pcnt_q == PCNT_LAST);

  // Pop only ever happens on a boundary; the FIFO itself suppresses pops when empty
  sample_fifo #(
    .WIDTH (INPUT_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid),
    .pop   (boundary),
    .wdata (in_data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_comb begin
    src = SRC_KEEP;
    if (!en) begin
      src = SRC_ZERO;
    end else if (boundary) begin
      src = fifo_empty ? UNDERRUN_SRC : SRC_HEAD;
    end

    case (src)
      SRC_ZERO: sample_d = '0;
      SRC_HEAD: sample_d = fifo_head >> vol_shift;
      default:  sample_d = sample_q;
    endcase

    pcnt_d         = en ? pcnt_q + 1'b1 : '0;
    period_start_d = boundary;

    // A fresh underrun beats a simultaneous clear request
    if (boundary && fifo_empty) begin
      underrun_d = 1'b1;
    end else if (clear_underrun) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q         <= '0;
      sample_q       <= '0;
      period_start_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      pcnt_q         <= pcnt_d;
      sample_q       <= sample_d;
      period_start_q <= period_start_d;
      underrun_q     <= underrun_d;
    end
  end

  assign in_ready     = !fifo_full;
  assign sample       = sample_q;
  assign period_start = period_start_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_sample_feeder.sv
// Self-checking bench for sample_feeder: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model and a period_start scoreboard.
module tb_sample_feeder;

  localparam int P     = 16;
  localparam int DEPTH = 8;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] vol_shift;
  logic       clear_underrun;
  logic [3:0] sample;
  logic       period_start;
  logic       underrun;
  logic [3:0] level;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  typedef struct {
    logic [3:0] s;
    logic       u;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] mq[$];
  int         phase    = 0;
  logic [3:0] m_sample = '0;
  logic       m_under  = 1'b0;
  logic       m_pstart = 1'b0;

  sample_feeder dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .vol_shift      (vol_shift),
    .clear_underrun (clear_underrun),
    .sample         (sample),
    .period_start   (period_start),
    .underrun       (underrun),
    .level          (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one set of inputs, then let exactly one rising edge consume them
  task automatic applyStimulus(input logic r, input logic e, input logic v,
                               input logic [3:0] d, input logic [1:0] vs, input logic c);
    reset          = r;
    en             = e;
    in_valid       = v;
    in_data        = d;
    vol_shift      = vs;
    clear_underrun = c;
    @(negedge clk);
  endtask

  task automatic runIdle(input int n, input logic e, input logic [1:0] vs, input logic c);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, e, 1'b0, 4'h0, vs, c);
  endtask

  // Reference model: one sample per P enabled cycles, taken from a plain queue
  always @(posedge clk) begin
    logic bnd;
    logic acc;
    logic was_empty;
    logic [3:0] head;
    logic [3:0] pushed;
    if (reset) begin
      mq.delete();
      exp_q.delete();
      phase    = 0;
      m_sample = '0;
      m_under  = 1'b0;
      m_pstart = 1'b0;
    end else begin
      bnd       = en && (phase == P - 1);
      was_empty = (mq.size() == 0);
      acc       = in_valid && (mq.size() < DEPTH);
      pushed    = in_data;
      m_pstart  = bnd;
      if (bnd) begin
        if (!was_empty) begin
          head     = mq.pop_front();
          m_sample = head >> vol_shift;
        end else begin
`ifndef SAMPLE_HOLD_ON_UNDERRUN_EN
          m_sample = '0;
`endif
        end
      end else if (!en) begin
        m_sample = '0;
      end
      if (bnd && was_empty) m_under = 1'b1;
      else if (clear_underrun) m_under = 1'b0;
      if (acc) mq.push_back(pushed);
      phase = en ? (phase + 1) % P : 0;
      if (bnd) exp_q.push_back('{m_sample, m_under});
    end
  end

  // Monitor: per-cycle state compare plus scoreboard pop on every period_start
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      checkOutput("level", 8'(level), 8'(mq.size()));
      checkOutput("in_ready", 8'(in_ready), 8'(mq.size() < DEPTH));
      checkOutput("underrun", 8'(underrun), 8'(m_under));
      checkOutput("sample", 8'(sample), 8'(m_sample));
      checkOutput("period_start", 8'(period_start), 8'(m_pstart));
      if (period_start === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("sb_unexpected_pstart", 8'(period_start), 8'h0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_sample", 8'(sample), 8'(e.s));
          checkOutput("sb_underrun", 8'(underrun), 8'(e.u));
        end
      end
    end
  end

  initial begin
    logic [3:0] hold_exp;
    int rate;
`ifdef SAMPLE_HOLD_ON_UNDERRUN_EN
    hold_exp = 4'h5;
`else
    hold_exp = 4'h0;
`endif
    reset = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = '0;
    vol_shift = '0; clear_underrun = 1'b0;
    @(negedge clk);

    applyStimulus(1, 0, 0, 4'h0, 0, 0);
    mon_en = 1'b1;
    checkOutput("rst_level", 8'(level), 8'h0);
    checkOutput("rst_sample", 8'(sample), 8'h0);
    checkOutput("rst_in_ready", 8'(in_ready), 8'h1);
    checkOutput("rst_underrun", 8'(underrun), 8'h0);
    checkOutput("rst_pstart", 8'(period_start), 8'h0);

    // Two samples queued up front come out on consecutive boundaries
    applyStimulus(0, 1, 1, 4'hF, 0, 0);
    applyStimulus(0, 1, 1, 4'h8, 0, 0);
    runIdle(13, 1, 0, 0);
    checkOutput("pre_bnd_sample", 8'(sample), 8'h0);
    applyStimulus(0, 1, 0, 4'h0, 0, 0);
    checkOutput("edge16_sample", 8'(sample), 8'hF);
    checkOutput("edge16_pstart", 8'(period_start), 8'h1);
    runIdle(1, 1, 0, 0);
    checkOutput("edge17_pstart", 8'(period_start), 8'h0);
    runIdle(15, 1, 0, 0);
    checkOutput("edge32_sample", 8'(sample), 8'h8);
    checkOutput("edge32_pstart", 8'(period_start), 8'h1);

    // Attenuation
    applyStimulus(1, 0, 0, 4'h0, 0, 0);
    applyStimulus(0, 1, 1, 4'hC, 2, 0);
    runIdle(15, 1, 2, 0);
    checkOutput("vol2_sample", 8'(sample), 8'h3);

    // Underrun, then clear colliding with a second underrun
    applyStimulus(1, 0, 0, 4'h0, 0, 0);
    applyStimulus(0, 1, 1, 4'h5, 0, 0);
    runIdle(15, 1, 0, 0);
    checkOutput("ur_prev_sample", 8'(sample), 8'h5);
    runIdle(16, 1, 0, 0);
    checkOutput("ur_flag", 8'(underrun), 8'h1);
    checkOutput("ur_sample", 8'(sample), 8'(hold_exp));
    runIdle(15, 1, 0, 0);
    applyStimulus(0, 1, 0, 4'h0, 0, 1);
    checkOutput("ur_set_beats_clear", 8'(underrun), 8'h1);
    applyStimulus(0, 1, 0, 4'h0, 0, 1);
    checkOutput("ur_cleared", 8'(underrun), 8'h0);

    // Push into an empty FIFO exactly on the boundary edge
    applyStimulus(1, 0, 0, 4'h0, 0, 0);
    runIdle(15, 1, 0, 0);
    applyStimulus(0, 1, 1, 4'h9, 0, 0);
    checkOutput("bndpush_underrun", 8'(underrun), 8'h1);
    checkOutput("bndpush_level", 8'(level), 8'h1);
    runIdle(16, 1, 0, 0);
    checkOutput("bndpush_sample", 8'(sample), 8'h9);
    checkOutput("bndpush_level_after", 8'(level), 8'h0);

    // Reset mid-period restarts the period counter
    applyStimulus(1, 0, 0, 4'h0, 0, 0);
    applyStimulus(0, 1, 1, 4'h1, 0, 0);
    applyStimulus(0, 1, 1, 4'h2, 0, 0);
    applyStimulus(0, 1, 1, 4'h3, 0, 0);
    runIdle(4, 1, 0, 0);
    checkOutput("midrst_level_before", 8'(level), 8'h3);
    applyStimulus(1, 1, 1, 4'h7, 0, 0);
    checkOutput("midrst_level", 8'(level), 8'h0);
    checkOutput("midrst_sample", 8'(sample), 8'h0);
    applyStimulus(0, 1, 1, 4'hA, 0, 0);
    runIdle(14, 1, 0, 0);
    checkOutput("midrst_no_early_bnd", 8'(period_start), 8'h0);
    applyStimulus(0, 1, 0, 4'h0, 0, 0);
    checkOutput("midrst_bnd_pstart", 8'(period_start), 8'h1);
    checkOutput("midrst_bnd_sample", 8'(sample), 8'hA);

    // Fill with playback disabled
    applyStimulus(1, 0, 0, 4'h0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 4'(i + 1), 0, 0);
    checkOutput("fill_level", 8'(level), 8'h8);
    checkOutput("fill_in_ready", 8'(in_ready), 8'h0);
    runIdle(20, 0, 0, 0);
    checkOutput("fill_no_pop", 8'(level), 8'h8);
    checkOutput("fill_sample", 8'(sample), 8'h0);

    // Randomized traffic with varying push rates
    for (int chunk = 0; chunk < 6; chunk++) begin
      rate = 4 + chunk * 6;
      for (int i = 0; i < 500; i++) begin
        applyStimulus($urandom_range(0, 299) == 0,
                      $urandom_range(0, 9) != 0,
                      $urandom_range(0, rate - 1) == 0,
                      4'($urandom_range(0, 15)),
                      2'($urandom_range(0, 3)),
                      $urandom_range(0, 39) == 0);
      end
    end

    runIdle(3, 0, 0, 0);
    checkOutput("sb_drained", 8'(exp_q.size()), 8'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_feeder.md
SAMPLE_FEEDER -- requirements
Module: sample_feeder

Interface
REQ-001 SHALL have parameter PULSE_PERIOD, default 16, meaning cycles per PWM period; effective period P = 2**$clog2(PULSE_PERIOD), with P >= 2.
REQ-002 SHALL have parameter INPUT_BITS, default 4, meaning sample width, equal to the downstream PWM converter's input width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning sample buffer entries; power of two, >= 2.
REQ-004 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port en  input  1  playback enable.
REQ-007 SHALL have port in_data  input  INPUT_BITS  upstream sample.
REQ-008 SHALL have port in_valid  input  1  in_data valid.
REQ-009 SHALL have port in_ready  output  1  FIFO can accept a sample.
REQ-010 SHALL have port vol_shift  input  2  attenuation, right-shift amount.
REQ-011 SHALL have port clear_underrun  input  1  clears the underrun flag.
REQ-012 SHALL have port sample  output  INPUT_BITS  value to the PWM converter input; held stable for a whole period.
REQ-013 SHALL have port period_start  output  1  one-cycle pulse in the cycle after sample updates.
REQ-014 SHALL have port underrun  output  1  sticky flag: a period boundary found the FIFO empty.
REQ-015 SHALL have port level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-016 SHALL push in_data when in_valid && in_ready; in_ready = (level < FIFO_DEPTH); a push never overwrites stored data.
REQ-017 SHALL run period counter pcnt 0..P-1 while en=1, wrapping P-1 -> 0; when en=0, pcnt SHALL be held at 0.
REQ-018 SHALL define the boundary edge as en=1 && pcnt==P-1; on it, if the FIFO is non-empty, it SHALL pop the head and load sample <= head >> vol_shift (logical shift, zero fill).
REQ-019 On a boundary with the FIFO empty, SHALL set underrun and load sample per REQ-027.
REQ-020 SHALL not bypass a push into a pop in the same edge: a push into an empty FIFO on a boundary edge still counts as an underrun, and the pushed entry remains stored.
REQ-021 Simultaneous push and pop with 0 < level < FIFO_DEPTH SHALL leave level unchanged.
REQ-022 SHALL assert period_start for exactly one cycle after each boundary edge, whether or not an underrun occurred.
REQ-023 SHALL clear underrun on clear_underrun=1; set SHALL win over clear in the same edge.
REQ-024 When en=0, sample SHALL become 0 on the next edge and no pops SHALL occur; pushes SHALL continue.
REQ-025 sample SHALL change only on boundary edges or per REQ-024, giving a fixed one-period latency: the downstream PWM converter, which reloads on the same edge, latches the previous value.

Reset
REQ-026 reset SHALL, with priority over all other inputs, set sample=0, period_start=0, underrun=0, pcnt=0, and level=0 (FIFO emptied), with in_ready=1 in the cycle after reset.

Configuration
REQ-027 When macro SAMPLE_HOLD_ON_UNDERRUN_EN is defined, an underrun SHALL keep the previous sample value; when undefined, an underrun SHALL load sample=0. Underrun flagging SHALL be identical in both builds.

Structure
REQ-028 SHALL place the default parameter constants and the period-length function (2**$clog2(x)) in shared package pwm_audio_pkg.
REQ-029 SHALL implement the buffer as sub-module sample_fifo (synchronous FIFO, registered full, empty and level), instantiated once.

Verification
REQ-030 Reset, en=1, push 4'hF, 4'h8 at once, vol_shift=0 -> sample=F after edge 16, 8 after edge 32; period_start high in cycles 17 and 33.
REQ-031 vol_shift=2, push 4'hC -> sample=3 at the next boundary.
REQ-032 Hold in_valid=1 with no boundaries (en=0) -> exactly 8 pushes accepted, then in_ready=0 and level=8; no pop while en=0.
REQ-033 Empty FIFO at a boundary, after previous sample 5 -> underrun=1 and sample=0 (5 with SAMPLE_HOLD_ON_UNDERRUN_EN); clear_underrun and a boundary underrun in the same edge -> underrun stays 1.
REQ-034 Assert reset mid-period with level=3 -> next cycle level=0, sample=0, and pcnt restarts so the first boundary is P edges later.
REQ-035 Push into an empty FIFO on a boundary edge -> underrun=1, level=1, and that sample is output one period later.
